// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and types for the general register file.
//   GRF_DATA_W / GRF_ADDR_W / GRF_PC_W / GRF_CNT_W : default widths
//   NUM_REGS, REG_ZERO, REG_RA                      : register space constants
//   trace_rec_t                                     : committed-write record {pc, a3, wd}
//   is_commit()                                     : write-commit qualifier
package grf_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_ADDR_W = 5;
  localparam int unsigned GRF_PC_W   = 32;
  localparam int unsigned GRF_CNT_W  = 32;
  localparam int unsigned NUM_REGS   = 2 ** GRF_ADDR_W;

  localparam logic [GRF_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [GRF_ADDR_W-1:0] REG_RA   = 5'd31;

  // Record of one committed write, as seen by the verification checker.
  typedef struct packed {
    logic [GRF_PC_W-1:0]   pc;
    logic [GRF_ADDR_W-1:0] a3;
    logic [GRF_DATA_W-1:0] wd;
  } trace_rec_t;

  // $0 is hardwired: writes to it never commit.
  function automatic logic is_commit(input logic we, input logic [GRF_ADDR_W-1:0] a3);
    return we && (a3 != REG_ZERO);
  endfunction

endpackage

// File: rtl/grf_bypass.sv
// grf_bypass: combinational read mux for one register-file read port.
//   ra     : read index
//   stored : value currently held in storage at ra
//   commit : a write is committing this cycle
//   a3, wd : index and data of that write
//   rd     : read data (0 for $0, write data on an index match, else stored)
module grf_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              commit,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  // $0 has priority; then same-cycle write-before-read forwarding.
  always_comb begin
    rd = stored;
    if (ra == '0) begin
      rd = '0;
    end else if (commit && (a3 == ra)) begin
      rd = wd;
    end
  end

endmodule

// File: rtl/grf.sv
// grf: MIPS general register file at the writeback end of the pipeline.
//   clk, reset                  : rising-edge clock, async active-high reset
//   we_i, a3_i, wd_i, pc_i      : writeback write request and its PC
//   a1_i, a2_i / rd1_o, rd2_o   : two combinational read ports with write bypass
//   trace_valid_o               : pulse, a write committed on the previous edge
//   trace_pc_o/a3_o/wd_o        : last committed write record (held when idle)
//   commit_cnt_o                : committed writes since reset (wrapping)
module grf
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] a3_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [31:0]       pc_i,
  input  logic [ADDR_W-1:0] a1_i,
  input  logic [ADDR_W-1:0] a2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic              trace_valid_o,
  output logic [31:0]       trace_pc_o,
  output logic [ADDR_W-1:0] trace_a3_o,
  output logic [DATA_W-1:0] trace_wd_o,
  output logic [31:0]       commit_cnt_o
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]    regs_q [NREGS];
  logic                 commit_c;
  logic                 trace_valid_q;
  trace_rec_t           trace_q;
  logic [GRF_CNT_W-1:0] commit_cnt_q;

  // Write qualifier shared by storage, bypass, trace and counter.
  assign commit_c = is_commit(we_i, GRF_ADDR_W'(a3_i));

  // Architectural storage; entry 0 is reset and never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_c) begin
      regs_q[a3_i] <= wd_i;
    end
  end

  // Commit trace: one-cycle pulse, record fields hold their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_q       <= '0;
    end else begin
      trace_valid_q <= commit_c;
      if (commit_c) begin
        trace_q.pc <= GRF_PC_W'(pc_i);
        trace_q.a3 <= GRF_ADDR_W'(a3_i);
        trace_q.wd <= GRF_DATA_W'(wd_i);
      end
    end
  end

  // Commit counter, wraps naturally at full width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_cnt_q <= '0;
    end else if (commit_c) begin
      commit_cnt_q <= commit_cnt_q + GRF_CNT_W'(1);
    end
  end

  // Read port 1 (rs).
  grf_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rd1 (
    .ra     (a1_i),
    .stored (regs_q[a1_i]),
    .commit (commit_c),
    .a3     (a3_i),
    .wd     (wd_i),
    .rd     (rd1_o)
  );

  // Read port 2 (rt).
  grf_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rd2 (
    .ra     (a2_i),
    .stored (regs_q[a2_i]),
    .commit (commit_c),
    .a3     (a3_i),
    .wd     (wd_i),
    .rd     (rd2_o)
  );

  assign trace_valid_o = trace_valid_q;
  assign trace_pc_o    = 32'(trace_q.pc);
  assign trace_a3_o    = ADDR_W'(trace_q.a3);
  assign trace_wd_o    = DATA_W'(trace_q.wd);
  assign commit_cnt_o  = 32'(commit_cnt_q);

endmodule

// File: tb/tb_grf.sv
// tb_grf: scoreboard bench for grf. Stimulus pushes the expected trace
// record for every committing write; a monitor pops and compares on each
// trace_valid_o pulse. Combinational reads are checked directly.
module tb_grf;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        tv;
  logic [31:0] tpc;
  logic [4:0]  ta3;
  logic [31:0] twd;
  logic [31:0] cnt;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt;
  logic [31:0] last_pc;
  int          checks;
  int          errors;

  grf dut (
    .clk           (clk),
    .reset         (reset),
    .we_i          (we),
    .a3_i          (a3),
    .wd_i          (wd),
    .pc_i          (pc),
    .a1_i          (a1),
    .a2_i          (a2),
    .rd1_o         (rd1),
    .rd2_o         (rd2),
    .trace_valid_o (tv),
    .trace_pc_o    (tpc),
    .trace_a3_o    (ta3),
    .trace_wd_o    (twd),
    .commit_cnt_o  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a write; if it should commit, model the count and queue the record.
  task automatic drive_write(input logic [4:0] a3v, input logic [31:0] wdv, input logic [31:0] pcv);
    exp_t e;
    we = 1'b1;
    a3 = a3v;
    wd = wdv;
    pc = pcv;
    if (a3v != 5'd0) begin
      exp_cnt = exp_cnt + 32'd1;
      e.pc  = pcv;
      e.a3  = a3v;
      e.wd  = wdv;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      last_pc = pcv;
    end
  endtask

  // Monitor: compare every trace pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (tv === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_trace: got pulse a3=%0d wd=0x%08h expected no pulse", ta3, twd);
        end else begin
          e = exp_q.pop_front();
          check("trace_pc", tpc, e.pc);
          check("trace_a3", 32'(ta3), 32'(e.a3));
          check("trace_wd", twd, e.wd);
          check("trace_cnt", cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 32'd0;
    last_pc = 32'd0;
    reset = 1'b1;
    we = 1'b0; a3 = '0; wd = '0; pc = '0; a1 = '0; a2 = '0;

    // Reset state: every index reads zero on both ports.
    #2;
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #0.1;
      check("reset_rd1", rd1, 32'd0);
      check("reset_rd2", rd2, 32'd0);
    end
    check("reset_cnt", cnt, 32'd0);
    check("reset_tv", 32'(tv), 32'd0);
    check("reset_tpc", tpc, 32'd0);

    // First write after reset release.
    @(negedge clk);
    reset = 1'b0;
    drive_write(5'd8, 32'h1234_5678, 32'h0000_3000);
    @(negedge clk);
    we = 1'b0; a1 = 5'd8;
    #1 check("rd1_r8", rd1, 32'h1234_5678);

    // Same-cycle bypass on both ports.
    @(negedge clk);
    drive_write(5'd9, 32'hAAAA_AAAA, 32'h0000_3004);
    @(negedge clk);
    we = 1'b0; a1 = 5'd9; a2 = 5'd9;
    #1 check("stored_r9", rd2, 32'hAAAA_AAAA);
    drive_write(5'd9, 32'h5555_5555, 32'h0000_3008);
    #1;
    check("bypass_rd1", rd1, 32'h5555_5555);
    check("bypass_rd2", rd2, 32'h5555_5555);
    @(negedge clk);
    we = 1'b0;
    #1 check("after_bypass_r9", rd1, 32'h5555_5555);

    // Bypass only on the matching port.
    drive_write(5'd10, 32'hCAFE_0010, 32'h0000_300C);
    a1 = 5'd8; a2 = 5'd10;
    #1;
    check("nobypass_rd1", rd1, 32'h1234_5678);
    check("bypass_rd2_r10", rd2, 32'hCAFE_0010);

    // Write to $0 is discarded.
    @(negedge clk);
    drive_write(5'd0, 32'hFFFF_FFFF, 32'h0000_3010);
    a1 = 5'd0;
    #1 check("zero_bypass", rd1, 32'd0);
    @(negedge clk);
    we = 1'b0;
    check("zero_no_trace", 32'(tv), 32'd0);
    check("zero_cnt", cnt, exp_cnt);
    check("trace_pc_hold", tpc, last_pc);
    #1 check("zero_read", rd1, 32'd0);

    // Back-to-back commits give consecutive pulses.
    drive_write(5'd1, 32'h0000_0001, 32'h0000_3014);
    @(negedge clk);
    drive_write(5'd2, 32'h0000_0002, 32'h0000_3018);
    @(negedge clk);
    drive_write(5'd3, 32'h0000_0003, 32'h0000_301C);
    @(negedge clk);
    we = 1'b0; a1 = 5'd1; a2 = 5'd3;
    #1;
    check("b2b_r1", rd1, 32'h0000_0001);
    check("b2b_r3", rd2, 32'h0000_0003);

    // Async reset mid-cycle clears storage and trace without an edge.
    @(negedge clk);
    drive_write(5'd31, 32'h0000_3010, 32'h0000_3020);
    @(negedge clk);
    we = 1'b0; a1 = 5'd31;
    #1 check("r31_stored", rd1, 32'h0000_3010);
    #2 reset = 1'b1;
    exp_cnt = 32'd0;
    #1;
    check("async_rd1", rd1, 32'd0);
    check("async_tv", 32'(tv), 32'd0);
    check("async_tpc", tpc, 32'd0);
    check("async_ta3", 32'(ta3), 32'd0);
    check("async_twd", twd, 32'd0);
    check("async_cnt", cnt, 32'd0);

    // Write held across an edge while in reset is lost.
    we = 1'b1; a3 = 5'd5; wd = 32'hDEAD_BEEF; pc = 32'h0000_3024;
    @(negedge clk);
    reset = 1'b0; we = 1'b0; a1 = 5'd5;
    #1;
    check("reset_wins_rd", rd1, 32'd0);
    check("reset_wins_cnt", cnt, 32'd0);

    // First edge after release accepts the write.
    @(negedge clk);
    drive_write(5'd6, 32'h0600_0006, 32'h0000_3028);
    @(negedge clk);
    we = 1'b0; a2 = 5'd6;
    #1 check("post_reset_r6", rd2, 32'h0600_0006);

    // Counter wrap: preload the counter then commit once.
    @(negedge clk);
    force dut.commit_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.commit_cnt_q;
    #1 check("cnt_preload", cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    drive_write(5'd4, 32'h0000_0044, 32'h0000_302C);
    @(negedge clk);
    we = 1'b0;
    check("cnt_wrap", cnt, 32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf.md
# grf

General register file at the consuming end of the writeback interface in the five-stage MIPS pipeline. It accepts the write enable, destination index, data and PC presented by the writeback stage and commits them into 31 architectural registers (`$0` is hardwired to zero). It serves two combinational read ports to decode, with internal write-to-read bypass, and emits a registered commit trace for the verification checker.

## Interface
- `DATA_W`, 32: register and data width.
- `ADDR_W`, 5: register index width; 2**ADDR_W registers.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high; clears all registers and trace outputs.
- `we_i`  in  1: write enable from writeback stage.
- `a3_i`  in  ADDR_W: destination register index.
- `wd_i`  in  DATA_W: write data.
- `pc_i`  in  32: PC of the instruction being written back.
- `a1_i`, `a2_i`  in  ADDR_W: read indices (rs, rt) from decode.
- `rd1_o`, `rd2_o`  out  DATA_W: read data for `a1_i`, `a2_i`.
- `trace_valid_o`  out  1: one-cycle pulse, a write committed on the previous edge.
- `trace_pc_o`  out  32; `trace_a3_o`  out  ADDR_W; `trace_wd_o`  out  DATA_W: committed write record.
- `commit_cnt_o`  out  32: count of committed writes since reset.

## Operation
- Commit condition: `we_i && a3_i != 0`; on commit, `regs[a3_i] <= wd_i` at rising `clk`.
- A write with `a3_i == 0` is discarded: no storage change, no trace, no count.
- Read: `rd1_o = (a1_i == 0) ? 0 : (commit && a3_i == a1_i) ? wd_i : regs[a1_i]`; same for `rd2_o` with `a2_i`.
- Bypass is purely combinational: a value written this cycle is visible on reads in the same cycle (write-before-read semantics).
- Both read ports may address the same register, including the one being written; both return `wd_i`.
- Trace: on commit, next edge sets `trace_valid_o=1` and latches `pc_i`, `a3_i`, `wd_i`; with no commit, `trace_valid_o=0` and the data fields hold their last value.
- `commit_cnt_o` increments by 1 per commit; wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (async, any time): all `regs` = 0, `trace_valid_o`=0, `trace_pc_o`=0, `trace_a3_o`=0, `trace_wd_o`=0, `commit_cnt_o`=0, effective immediately; `rd*_o` then read 0.
- Reset asserted on the same edge as a write: reset wins, the write is lost.
- First edge after reset deassertion accepts writes normally.
- Write latency: storage updated at the edge; read-after-write in the same cycle covered by bypass, so decode needs no extra stall for a writeback-stage producer.
- Trace latency: exactly one cycle after commit edge; back-to-back commits yield consecutive pulses.
- Read ports: zero latency, no clock dependence other than stored state.

## Structure
- Shared package: `NUM_REGS`, `REG_ZERO` (5'd0), `REG_RA` (5'd31), data-width constant, trace record typedef (`pc`, `a3`, `wd`).
- One sub-module is natural: `grf_bypass`, a combinational read mux (index, stored value, commit, a3, wd -> data), instantiated once per read port.
- Storage, commit logic, trace registers and counter live in the top.

## Test plan
- Reset then read all 32 indices on both ports -> all 0; `commit_cnt_o`=0, `trace_valid_o`=0.
- `we_i`=1, `a3_i`=8, `wd_i`=0x1234_5678, `pc_i`=0x3000 -> next cycle `rd1_o`(a1=8)=0x1234_5678; `trace_valid_o`=1, trace = {0x3000, 8, 0x1234_5678}; count=1.
- Same-cycle bypass: reg 9 holds 0xAAAA_AAAA, drive write reg 9 = 0x5555_5555 with `a1_i`=`a2_i`=9 -> both reads 0x5555_5555 before the edge.
- Write `a3_i`=0, `wd_i`=0xFFFF_FFFF -> `rd1_o`(a1=0)=0, no trace pulse, count unchanged.
- Write reg 31 = 0x3010 then assert `reset` asynchronously mid-cycle -> reg 31 and all trace/count outputs read 0 immediately, without a clock edge.
- Preload counter path with 0xFFFF_FFFF commits (force/backdoor) then one commit -> `commit_cnt_o`=0.
